hazard_scoreboard: RTL and testbench

//  Parametrised successor to the fixed forwarding and hazard-detection pair in the 5-stage core.

---
 rtl/hazard_scoreboard.sv | 132 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes in a DEPTH-slot shift register
// (slot 0 = EX ... slot DEPTH-1 = WB). For every ID read port it decides whether the
// instruction must stall or which source the EX operand mux should select.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   iss_v_i/we_i      ID holds a valid instruction / that instruction writes a register
//   iss_rd_i          destination register of the ID instruction
//   iss_lat_i         first slot from which its result is forwardable (0 -> 1, clamped to DEPTH-1)
//   rd_en_i           per-port source-used flag
//   rd_addr_i         packed source addresses, port p = [p*AW +: AW]
//   flush_i           squash the ID instruction
//   stall_o           combinational stall request
//   fwd_sel_ex_o      registered forward selects: 0 regfile, j slot j, DEPTH WB hold register
//   stall_cnt_o       saturating stall-cycle counter
//
// Optional feature macro: REGFILE_WRITE_THROUGH_EN
//   defined   -> a match in slot DEPTH-1 reads the regfile (sel 0, write-through)
//   undefined -> a match in slot DEPTH-1 selects the WB hold register (sel DEPTH)
module hazard_scoreboard #(
  parameter int unsigned AW    = 5,
  parameter int unsigned NRD   = 2,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned LAT_W = 3,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned FSEL_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    iss_v_i,
  input  logic                    iss_we_i,
  input  logic [AW-1:0]           iss_rd_i,
  input  logic [LAT_W-1:0]        iss_lat_i,
  input  logic [NRD-1:0]          rd_en_i,
  input  logic [NRD*AW-1:0]       rd_addr_i,
  input  logic                    flush_i,
  output logic                    stall_o,
  output logic [NRD*FSEL_W-1:0]   fwd_sel_ex_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);

`ifdef REGFILE_WRITE_THROUGH_EN
  localparam logic [FSEL_W-1:0] WbSel = '0;
`else
  localparam logic [FSEL_W-1:0] WbSel = FSEL_W'(DEPTH);
`endif

  logic [DEPTH-1:0]      slot_v_q;
  logic [AW-1:0]         slot_rd_q  [DEPTH];
  logic [LAT_W-1:0]      slot_lat_q [DEPTH];
  logic [NRD*FSEL_W-1:0] fwd_sel_q, fwd_sel_d;
  logic [CNT_W-1:0]      stall_cnt_q;

  logic [LAT_W-1:0]      iss_lat_eff;
  logic [NRD-1:0]        port_haz;
  logic [FSEL_W-1:0]     port_sel [NRD];
  logic [AW-1:0]         src;
  logic                  stall;
  logic                  issue;

  // Latency is normalised once at issue so the slot compare stays simple.
  always_comb begin
    iss_lat_eff = iss_lat_i;
    if (iss_lat_i == '0) begin
      iss_lat_eff = LAT_W'(1);
    end else if (int'(iss_lat_i) > int'(DEPTH) - 1) begin
      iss_lat_eff = LAT_W'(DEPTH - 1);
    end
  end

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    port_haz = '0;
    src      = '0;
    for (int p = 0; p < int'(NRD); p++) begin
      port_sel[p] = '0;
      src         = rd_addr_i[p*AW +: AW];
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (rd_en_i[p] && slot_v_q[k] && (slot_rd_q[k] == src) && (src != '0)) begin
          // Consumer reaches EX when the producer sits in slot k+1.
          port_haz[p] = (k + 1) < int'(slot_lat_q[k]);
          if (k == int'(DEPTH) - 1) begin
            port_sel[p] = WbSel;
          end else begin
            port_sel[p] = FSEL_W'(k + 1);
          end
        end
      end
    end
  end

  assign stall = iss_v_i & ~flush_i & (|port_haz);
  assign issue = iss_v_i & iss_we_i & ~stall & ~flush_i;

  always_comb begin
    fwd_sel_d = '0;
    if (!(stall || flush_i || !iss_v_i)) begin
      for (int p = 0; p < int'(NRD); p++) begin
        fwd_sel_d[p*FSEL_W +: FSEL_W] = port_sel[p];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_v_q    <= '0;
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        slot_rd_q[k]  <= '0;
        slot_lat_q[k] <= '0;
      end
    end else begin
      slot_v_q      <= {slot_v_q[DEPTH-2:0], issue};
      slot_rd_q[0]  <= iss_rd_i;
      slot_lat_q[0] <= iss_lat_eff;
      for (int k = 1; k < int'(DEPTH); k++) begin
        slot_rd_q[k]  <= slot_rd_q[k-1];
        slot_lat_q[k] <= slot_lat_q[k-1];
      end
      fwd_sel_q <= fwd_sel_d;
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_o      = stall;
  assign fwd_sel_ex_o = fwd_sel_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised bench for hazard_scoreboard. The reference model keeps a queue of in-flight
// writers tagged with their age in cycles; hazards and selects follow from the ages.
module tb_hazard_scoreboard;
  localparam int AW     = 5;
  localparam int NRD    = 2;
  localparam int DEPTH  = 3;
  localparam int LAT_W  = 3;
  localparam int CNT_W  = 4;
  localparam int FSEL_W = $clog2(DEPTH + 1);
`ifdef REGFILE_WRITE_THROUGH_EN
  localparam int WB_SEL = 0;
`else
  localparam int WB_SEL = DEPTH;
`endif

  logic                  clk = 1'b0;
  logic                  rst, iss_v, iss_we, flush;
  logic [AW-1:0]         iss_rd;
  logic [LAT_W-1:0]      iss_lat;
  logic [NRD-1:0]        rd_en;
  logic [NRD*AW-1:0]     rd_addr;
  logic                  stall_o;
  logic [NRD*FSEL_W-1:0] fwd_sel_ex_o;
  logic [CNT_W-1:0]      stall_cnt_o;

  hazard_scoreboard #(
    .AW(AW), .NRD(NRD), .DEPTH(DEPTH), .LAT_W(LAT_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .iss_v_i(iss_v), .iss_we_i(iss_we), .iss_rd_i(iss_rd),
    .iss_lat_i(iss_lat), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .flush_i(flush),
    .stall_o(stall_o), .fwd_sel_ex_o(fwd_sel_ex_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    int            lat;
    int            age;
  } ent_t;

  ent_t                  q[$];
  logic [NRD*FSEL_W-1:0] exp_fwd;
  int                    exp_cnt;
  int                    n_cmp = 0;
  int                    n_bad = 0;

  task automatic check_eq(input string tag, input longint unsigned obs,
                          input longint unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one ID cycle, check stall_o, advance the model, then check registered outputs.
  task automatic step(input logic v, input logic we, input logic [AW-1:0] rd,
                      input logic [LAT_W-1:0] lat, input logic [NRD-1:0] en,
                      input logic [NRD*AW-1:0] addr, input logic fl, input logic rs);
    int   sel [NRD];
    logic anyhaz, exp_stall;
    int   best, a, l;
    ent_t nq[$];
    ent_t e;
    iss_v = v; iss_we = we; iss_rd = rd; iss_lat = lat;
    rd_en = en; rd_addr = addr; flush = fl; rst = rs;
    #2;
    anyhaz = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      sel[p] = 0;
      best   = -1;
      if (en[p] && addr[p*AW +: AW] != '0) begin
        foreach (q[i]) begin
          if (q[i].rd == addr[p*AW +: AW] && (best < 0 || q[i].age < q[best].age)) best = i;
        end
      end
      if (best >= 0) begin
        a = q[best].age;
        if (a + 1 < q[best].lat) anyhaz = 1'b1;
        sel[p] = (a == DEPTH - 1) ? WB_SEL : a + 1;
      end
    end
    exp_stall = v && !fl && anyhaz;
    check_eq("stall", stall_o, exp_stall);
    if (rs) begin
      q.delete();
      exp_fwd = '0;
      exp_cnt = 0;
    end else begin
      foreach (q[i]) begin
        if (q[i].age + 1 < DEPTH) begin
          e = q[i];
          e.age++;
          nq.push_back(e);
        end
      end
      if (v && we && !exp_stall && !fl) begin
        l = (lat == 0) ? 1 : int'(lat);
        if (l > DEPTH - 1) l = DEPTH - 1;
        nq.push_back('{rd: rd, lat: l, age: 0});
      end
      q = nq;
      exp_fwd = '0;
      if (!(exp_stall || fl || !v)) begin
        for (int p = 0; p < NRD; p++) exp_fwd[p*FSEL_W +: FSEL_W] = FSEL_W'(sel[p]);
      end
      if (exp_stall && exp_cnt != (1 << CNT_W) - 1) exp_cnt++;
    end
    @(posedge clk);
    #1;
    check_eq("fwd_sel", fwd_sel_ex_o, exp_fwd);
    check_eq("stall_cnt", stall_cnt_o, exp_cnt);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [AW-1:0]     a0, a1;
    logic [NRD*AW-1:0] pk;
    rst = 1'b1; iss_v = 1'b0; iss_we = 1'b0; iss_rd = '0; iss_lat = '0;
    rd_en = '0; rd_addr = '0; flush = 1'b0;
    exp_fwd = '0; exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_fwd", fwd_sel_ex_o, 0);
    check_eq("rst_cnt", stall_cnt_o, 0);
    check_eq("rst_stall", stall_o, 0);

    // ALU to ALU
    step(1'b1, 1'b1, 5'd8, 3'd1, 2'b00, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 3'd1, 2'b01, {5'd0, 5'd8}, 1'b0, 1'b0);
    check_eq("alu_sel_p0", fwd_sel_ex_o[FSEL_W-1:0], 1);
    idle(); idle(); idle();
    // Load-use: one stall, then the reissue forwards from slot 2
    step(1'b1, 1'b1, 5'd9, 3'd2, 2'b00, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 3'd1, 2'b10, {5'd9, 5'd0}, 1'b0, 1'b0);
    check_eq("lu_cnt", stall_cnt_o, 1);
    step(1'b1, 1'b0, 5'd0, 3'd1, 2'b10, {5'd9, 5'd0}, 1'b0, 1'b0);
    check_eq("lu_sel_p1", fwd_sel_ex_o[FSEL_W +: FSEL_W], 2);
    idle(); idle(); idle();
    // Register zero never matches
    step(1'b1, 1'b1, 5'd0, 3'd2, 2'b00, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 3'd1, 2'b11, '0, 1'b0, 1'b0);
    check_eq("r0_sel", fwd_sel_ex_o, 0);
    idle(); idle(); idle();
    // Youngest wins
    step(1'b1, 1'b1, 5'd5, 3'd1, 2'b00, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd5, 3'd1, 2'b00, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 3'd1, 2'b01, {5'd0, 5'd5}, 1'b0, 1'b0);
    check_eq("young_sel", fwd_sel_ex_o[FSEL_W-1:0], 1);
    idle(); idle(); idle();
    // Match in the WB slot
    step(1'b1, 1'b1, 5'd12, 3'd1, 2'b00, '0, 1'b0, 1'b0);
    idle(); idle();
    step(1'b1, 1'b0, 5'd0, 3'd1, 2'b01, {5'd0, 5'd12}, 1'b0, 1'b0);
    check_eq("wb_sel", fwd_sel_ex_o[FSEL_W-1:0], WB_SEL);
    idle(); idle(); idle();
    // Flush during a load-use hazard
    step(1'b1, 1'b1, 5'd9, 3'd2, 2'b00, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd3, 3'd1, 2'b01, {5'd0, 5'd9}, 1'b1, 1'b0);
    check_eq("flush_sel", fwd_sel_ex_o, 0);
    idle(); idle(); idle();
    // Reset mid-stall
    step(1'b1, 1'b1, 5'd7, 3'd2, 2'b00, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 3'd1, 2'b01, {5'd0, 5'd7}, 1'b0, 1'b1);
    check_eq("rstmid_cnt", stall_cnt_o, 0);
    step(1'b1, 1'b0, 5'd0, 3'd1, 2'b01, {5'd0, 5'd7}, 1'b0, 1'b0);
    check_eq("rstmid_fwd", fwd_sel_ex_o, 0);

    // Random traffic over a small register range so hazards are frequent
    for (int n = 0; n < 3000; n++) begin
      a0 = AW'($urandom_range(0, 7));
      a1 = AW'($urandom_range(0, 7));
      pk = {a1, a0};
      step(($urandom_range(0, 9) < 8), $urandom_range(0, 1) == 1,
           AW'($urandom_range(0, 7)), LAT_W'($urandom_range(0, 7)),
           NRD'($urandom_range(0, 3)), pk,
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 255) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
